// File: rtl/char_line_ctrl_pkg.sv
// Shared constants for the on-screen text line: glyph codes,
// default glyph geometry and the copy FSM state type.
package char_line_ctrl_pkg;

  localparam int MAX_CHARS_D    = 8;
  localparam int CHAR_W_D       = 26;
  localparam int CHAR_H_D       = 40;
  localparam int GAP_D          = 6;
  localparam int CODE_W_D       = 5;
  localparam int BLINK_FRAMES_D = 30;

  localparam logic [4:0] G_BLANK = 5'd0;
  localparam logic [4:0] G_0     = 5'd1;
  localparam logic [4:0] G_1     = 5'd2;
  localparam logic [4:0] G_2     = 5'd3;
  localparam logic [4:0] G_3     = 5'd4;
  localparam logic [4:0] G_4     = 5'd5;
  localparam logic [4:0] G_5     = 5'd6;
  localparam logic [4:0] G_6     = 5'd7;
  localparam logic [4:0] G_7     = 5'd8;
  localparam logic [4:0] G_8     = 5'd9;
  localparam logic [4:0] G_9     = 5'd10;
  localparam logic [4:0] G_A     = 5'd11;
  localparam logic [4:0] G_E     = 5'd12;
  localparam logic [4:0] G_G     = 5'd13;
  localparam logic [4:0] G_M     = 5'd14;
  localparam logic [4:0] G_O     = 5'd15;
  localparam logic [4:0] G_R     = 5'd16;
  localparam logic [4:0] G_V     = 5'd17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_COPY
  } state_e;

endpackage

// File: rtl/char_slot_match.sv
// Cell-hit comparator for one fixed slot of the text line.
// Sums are 11 bits wide so cells past x=1023 simply never match.
module char_slot_match
  import char_line_ctrl_pkg::*;
#(
  parameter int IDX    = 0,
  parameter int PITCH  = CHAR_W_D + GAP_D,
  parameter int CHAR_W = CHAR_W_D,
  parameter int CHAR_H = CHAR_H_D
) (
  input  logic [9:0]  x_i,
  input  logic [9:0]  y_i,
  input  logic [9:0]  base_x_i,
  input  logic [9:0]  base_y_i,
  output logic        hit_o,
  output logic [10:0] start_x_o
);

  logic [10:0] sx, sy, xe, ye;

  assign sx = {1'b0, base_x_i} + 11'(IDX * PITCH);
  assign sy = {1'b0, base_y_i};
  assign xe = {1'b0, x_i};
  assign ye = {1'b0, y_i};

  assign hit_o = (xe >= sx) && (xe < sx + 11'(CHAR_W)) &&
                 (ye >= sy) && (ye < sy + 11'(CHAR_H));
  assign start_x_o = sx;

endmodule

// File: rtl/char_line_ctrl.sv
// Text-line sequencer: shadow/active glyph buffers, vblank copy FSM,
// blink timer and a one-cycle registered pixel lookup.
module char_line_ctrl
  import char_line_ctrl_pkg::*;
#(
  parameter int MAX_CHARS    = MAX_CHARS_D,
  parameter int CHAR_W       = CHAR_W_D,
  parameter int CHAR_H       = CHAR_H_D,
  parameter int GAP          = GAP_D,
  parameter int CODE_W       = CODE_W_D,
  parameter int BLINK_FRAMES = BLINK_FRAMES_D,
  localparam int AW          = $clog2(MAX_CHARS),
  localparam int LW          = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [CODE_W-1:0] wr_code,
  output logic              wr_ready,
  input  logic              commit,
  input  logic [9:0]        base_x,
  input  logic [9:0]        base_y,
  input  logic [LW-1:0]     len,
  input  logic              blink_en,
  input  logic              frame_start,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [9:0]        x_d,
  output logic [9:0]        y_d,
  output logic [CODE_W-1:0] glyph_code,
  output logic [31:0]       glyph_x,
  output logic [31:0]       glyph_y,
  output logic              glyph_valid
);

  localparam int PITCH = CHAR_W + GAP;
  localparam int BCW   = $clog2(BLINK_FRAMES + 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [CODE_W-1:0] shadow_q [MAX_CHARS];
  logic [CODE_W-1:0] active_q [MAX_CHARS];
  logic [LW-1:0]     len_q, len_clamp;
  logic [9:0]        bx_q, by_q;
  logic [BCW-1:0]    bcnt_q;
  logic              boff_q;

  logic [9:0]        xd_q, yd_q;
  logic [CODE_W-1:0] code_q;
  logic [10:0]       gx_q;
  logic [9:0]        gy_q;
  logic              valid_q;

  logic [MAX_CHARS-1:0] hit;
  logic [10:0]          sx [MAX_CHARS];
  logic                 found, vis;
  logic [CODE_W-1:0]    sel_code;
  logic [10:0]          sel_x;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: if (commit) state_d = S_PEND;
      S_PEND: begin
        if (frame_start) begin
          state_d = S_COPY;
          idx_d   = '0;
        end
      end
      S_COPY: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(MAX_CHARS - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_ready  = (state_q == S_IDLE);
  assign len_clamp = (len > LW'(MAX_CHARS)) ? LW'(MAX_CHARS) : len;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      for (int i = 0; i < MAX_CHARS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (wr_en && wr_ready) shadow_q[wr_addr] <= wr_code;
      if (state_q == S_COPY) begin
        active_q[idx_q] <= shadow_q[idx_q];
        if (idx_q == '0) begin
          bx_q  <= base_x;
          by_q  <= base_y;
          len_q <= len_clamp;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !blink_en) begin
      bcnt_q <= '0;
      boff_q <= 1'b0;
    end else if (frame_start) begin
      if (bcnt_q == BCW'(BLINK_FRAMES - 1)) begin
        bcnt_q <= '0;
        boff_q <= ~boff_q;
      end else begin
        bcnt_q <= bcnt_q + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < MAX_CHARS; g++) begin : g_slot
    char_slot_match #(
      .IDX    (g),
      .PITCH  (PITCH),
      .CHAR_W (CHAR_W),
      .CHAR_H (CHAR_H)
    ) u_slot (
      .x_i       (x),
      .y_i       (y),
      .base_x_i  (bx_q),
      .base_y_i  (by_q),
      .hit_o     (hit[g]),
      .start_x_o (sx[g])
    );
  end

  // Cells never overlap (PITCH > CHAR_W), so at most one slot hits.
  always_comb begin
    found    = 1'b0;
    sel_code = '0;
    sel_x    = '0;
    for (int i = 0; i < MAX_CHARS; i++) begin
      if (hit[i] && (LW'(i) < len_q)) begin
        found    = 1'b1;
        sel_code = active_q[i];
        sel_x    = sx[i];
      end
    end
    vis = found && (sel_code != '0) && !boff_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xd_q    <= '0;
      yd_q    <= '0;
      code_q  <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      xd_q    <= x;
      yd_q    <= y;
      valid_q <= vis;
      code_q  <= vis ? sel_code : '0;
      if (vis) begin
        gx_q <= sel_x;
        gy_q <= by_q;
      end
    end
  end

  assign x_d         = xd_q;
  assign y_d         = yd_q;
  assign glyph_code  = code_q;
  assign glyph_x     = 32'(gx_q);
  assign glyph_y     = 32'(gy_q);
  assign glyph_valid = valid_q;

endmodule
